// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder: controller states and
// decimal-correction constants.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_CORR      = 4'd6;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: binary add of two digits plus carry, then +6
// correction whenever the decimal carry is produced.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] bin;

    always_comb begin
        bin  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        // Decimal carry covers both a binary overflow and a 4-bit sum of 10..15.
        cout = bin[4] | (bin[3] & bin[2]) | (bin[3] & bin[1]);
        s    = cout ? (bin[3:0] + BCD_CORR) : bin[3:0];
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder sequencer (IDLE -> ADD -> DONE) around one
// shared bcd_digit_add. Optional invalid-digit flag under `BCD_ERR_EN.
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout
`ifdef BCD_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_sh_q, a_sh_d;
    logic [W-1:0]     b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     work_q, work_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [3:0]       digit_s;
    logic             digit_c;
`ifdef BCD_ERR_EN
    logic             err_flag_q, err_flag_d;
    logic             err_q, err_d;
`endif

    bcd_digit_add u_digit_add (
        .a    (a_sh_q[3:0]),
        .b    (b_sh_q[3:0]),
        .cin  (carry_q),
        .s    (digit_s),
        .cout (digit_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef BCD_ERR_EN
        err_flag_d = err_flag_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADD;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    idx_d   = '0;
                    work_d  = '0;
`ifdef BCD_ERR_EN
                    err_flag_d = 1'b0;
`endif
                end
            end
            ADD: begin
                // New digit enters at the top so digit 0 ends up at the bottom.
                work_d  = (work_q >> 4) | (W'(digit_s) << (W - 4));
                carry_d = digit_c;
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                idx_d   = idx_q + IDX_W'(1);
`ifdef BCD_ERR_EN
                err_flag_d = err_flag_q | (a_sh_q[3:0] > BCD_MAX_DIGIT)
                                        | (b_sh_q[3:0] > BCD_MAX_DIGIT);
`endif
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    sum_d   = work_d;
                    cout_d  = digit_c;
`ifdef BCD_ERR_EN
                    err_d   = err_flag_d;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef BCD_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef BCD_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Operand/working registers are reloaded on every accept, so they carry no reset.
    always_ff @(posedge clk) begin
        a_sh_q  <= a_sh_d;
        b_sh_q  <= b_sh_d;
        carry_q <= carry_d;
        work_q  <= work_d;
`ifdef BCD_ERR_EN
        err_flag_q <= err_flag_d;
`endif
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef BCD_ERR_EN
    assign err  = err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl (DIGITS=4); exercises the
// err output as well when BCD_ERR_EN is defined.
module tb_bcd_serial_adder_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef BCD_ERR_EN
    logic         err;
`endif

    int checks   = 0;
    int failures = 0;

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef BCD_ERR_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Decimal reference: add as integers, split into DIGITS-digit result and carry.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         output logic [W-1:0] es, output logic ec);
        int lim = 1;
        int t;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        t  = bcd2int(ma) + bcd2int(mb) + int'(mc);
        ec = (t >= lim);
        es = int2bcd(t % lim);
    endtask

    // Accepts one operation and observes it until busy drops (bounded).
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                          output logic [W-1:0] os, output logic oc,
                          output int done_edge, output int busy_cyc, output int done_cyc);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; cin = ic;
        @(posedge clk); #1;
        start = 1'b0; a = rand_bcd(); b = rand_bcd(); cin = 1'($urandom);
        done_edge = -1; busy_cyc = 0; done_cyc = 0; os = '0; oc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc++;
                if (done_edge < 0) begin
                    done_edge = k; os = sum; oc = cout;
                end
            end
            if (!busy) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (sum !== '0) begin failures++; $display("FAIL reset_sum got=%h want=0000", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b want=0", cout); end
`ifdef BCD_ERR_EN
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{16'h1234, 16'h9999, 16'h0000, 16'h4999};
        logic [W-1:0] tb [4] = '{16'h5678, 16'h0001, 16'h0000, 16'h5000};
        logic         tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] ts [4] = '{16'h6912, 16'h0000, 16'h0001, 16'h0000};
        logic         to [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] gs;
        logic         gc;
        int de, bc, dc;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], tc[i], gs, gc, de, bc, dc);
            checks++; if (gs !== ts[i]) begin failures++; $display("FAIL dir%0d_sum got=%h want=%h", i, gs, ts[i]); end
            checks++; if (gc !== to[i]) begin failures++; $display("FAIL dir%0d_cout got=%b want=%b", i, gc, to[i]); end
            checks++; if (de !== DIGITS) begin failures++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, de, DIGITS); end
            checks++; if (bc !== DIGITS + 1) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", i, bc, DIGITS + 1); end
            checks++; if (dc !== 1) begin failures++; $display("FAIL dir%0d_done_width got=%0d want=1", i, dc); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, gs, es;
        logic         rc, gc, ec;
        int de, bc, dc;
        for (int i = 0; i < 40; i++) begin
            ra = rand_bcd(); rb = rand_bcd(); rc = 1'($urandom);
            model(ra, rb, rc, es, ec);
            run_op(ra, rb, rc, gs, gc, de, bc, dc);
            checks++; if (gs !== es || gc !== ec) begin
                failures++;
                $display("FAIL rand%0d_result a=%h b=%h cin=%b got=%b/%h want=%b/%h", i, ra, rb, rc, gc, gs, ec, es);
            end
            checks++; if (de !== DIGITS || dc !== 1) begin
                failures++; $display("FAIL rand%0d_timing done_edge=%0d done_cycles=%0d want=%0d/1", i, de, dc, DIGITS);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] a0, b0, xa, xb, es, e0s;
        logic         xc, ec, e0c;
        int seen;
        a0 = rand_bcd(); b0 = rand_bcd();
        model(a0, b0, 1'b0, e0s, e0c);
        @(negedge clk);
        start = 1'b1; a = a0; b = b0; cin = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                checks++; if (done !== 1'b1) begin failures++; $display("FAIL ign_done got=%b want=1", done); end
                checks++; if (sum !== e0s || cout !== e0c) begin
                    failures++; $display("FAIL ign_first_result got=%b/%h want=%b/%h", cout, sum, e0c, e0s);
                end
            end
            start = 1'b1; a = rand_bcd(); b = rand_bcd(); cin = 1'($urandom);
            @(posedge clk); #1;
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_idle_after_done busy got=%b want=0", busy); end
        xa = rand_bcd(); xb = rand_bcd(); xc = 1'($urandom);
        a = xa; b = xb; cin = xc;
        model(xa, xb, xc, es, ec);
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_reaccept busy got=%b want=1", busy); end
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            if (done) seen = 1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (seen !== 1 || sum !== es || cout !== ec) begin
            failures++; $display("FAIL ign_second_result seen=%0d got=%b/%h want=%b/%h", seen, cout, sum, ec, es);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] gs, es;
        logic         gc, ec;
        int de, bc, dc, done_cnt, busy_cnt;
        run_op(16'h1234, 16'h5678, 1'b1, gs, gc, de, bc, dc);
        checks++; if (gs !== 16'h6913) begin failures++; $display("FAIL pre_reset_sum got=%h want=6913", gs); end
        @(negedge clk);
        start = 1'b1; a = 16'h9999; b = 16'h9999; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b want=0", done); end
        checks++; if (sum !== '0) begin failures++; $display("FAIL midrst_sum got=%h want=0000", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL midrst_cout got=%b want=0", cout); end
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0; busy_cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        checks++; if (done_cnt !== 0 || busy_cnt !== 0) begin
            failures++; $display("FAIL midrst_quiet done_cycles=%0d busy_cycles=%0d want=0/0", done_cnt, busy_cnt);
        end
        model(16'h0456, 16'h0789, 1'b0, es, ec);
        run_op(16'h0456, 16'h0789, 1'b0, gs, gc, de, bc, dc);
        checks++; if (gs !== es || gc !== ec || de !== DIGITS) begin
            failures++; $display("FAIL midrst_recover got=%b/%h edge=%0d want=%b/%h edge=%0d", gc, gs, de, ec, es, DIGITS);
        end
    endtask

`ifdef BCD_ERR_EN
    task automatic test_err();
        logic [W-1:0] gs;
        logic         gc;
        int de, bc, dc;
        run_op(16'h00A0, 16'h0000, 1'b0, gs, gc, de, bc, dc);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=1", err); end
        checks++; if (gs !== 16'h0100 || gc !== 1'b0) begin
            failures++; $display("FAIL err_sum got=%b/%h want=0/0100", gc, gs);
        end
        run_op(16'h0001, 16'h0001, 1'b0, gs, gc, de, bc, dc);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b want=0", err); end
        checks++; if (gs !== 16'h0002) begin failures++; $display("FAIL err_next_sum got=%h want=0002", gs); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_random();
        test_reset_mid();
`ifdef BCD_ERR_EN
        test_err();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
